id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register for the 5-stage MIPS core. Captures the decoder's control bundle plus
//  operands from the ID stage and presents them to EX. Contains load-use hazard detection: on a
//  hazard it stalls IF/ID and injects a bubble into EX. Also honours an EX-stage flush and a downstream hold.
// PARAMETERS
//  DATA_W      32  width of register operands, extended immediate, PC
//  REG_ADDR_W   5  register-file address width
// PORTS
//  clk            in   1                 core clock, rising edge
//  rst            in   1                 asynchronous reset, active-low (0 = reset)
//  Regfile_weD    in   1                 decoder regfile write enable
//  DataMem_weD    in   1                 decoder data-memory write enable
//  aluOpD         in   `ALU_OP_LENGTH    decoder ALU operation
//  aluSrc2_muxD   in   1                 decoder ALU src2 select
//  regSrc_muxD    in   `REG_SRC_LENGTH   decoder writeback source select
//  regDst_muxD    in   `REG_DST_LENGTH   decoder destination select
//  memToRegD      in   1                 decoder load flag
//  pcD            in   DATA_W            ID-stage PC
//  rsDataD/rtDataD in  DATA_W            register-file read data
//  immExtD        in   DATA_W            extended immediate
//  rsD/rtD/rdD    in   REG_ADDR_W        ID-stage register addresses
//  flushE         in   1                 kill the instruction entering EX next edge
//  stallE         in   1                 downstream hold; EX register keeps its contents
//  stallF/stallD  out  1                 freeze PC and IF/ID register (combinational)
//  validE         out  1                 EX slot holds a real instruction
//  <sig>E         out  same as <sig>D    registered copies of every D input above (Regfile_weE ... rdE)
// BEHAVIOUR
//  - Reset (rst=0, async): every registered output, including validE, is 0. The outputs stay 0 until the first rising edge after rst=1.
//  - Hazard (combinational):
//      loadUse = validE & memToRegE & Regfile_weE & (rtE!=0) & (rtE==rsD | rtE==rtD).
//  - Stall outputs: stallF = stallD = loadUse | stallE.
//  - Register update on each rising edge, priority high->low:
//      1. flushE=1: bubble. All control outputs = 0; validE = 0; data/address outputs = 0.
//      2. stallE=1: hold. All E outputs keep their values.
//      3. loadUse=1: bubble, as in 1. The ID instruction is held upstream by stallD and re-enters next cycle.
//      4. Otherwise: load all D inputs; validE <= 1.
//  - Latency: 1 cycle D->E. A load-use pair costs exactly 1 bubble cycle.
//  - A bubble's control outputs are all zero, so it never writes the regfile or memory.
//  - Simultaneous cases:
//      flushE together with loadUse: flush wins, and stallF/stallD still assert for that cycle.
//      stallE together with loadUse: hold wins, and the bubble is deferred until stallE drops.
//  - rtE==0 never raises a hazard: $zero is not a dependence.
//  - Reset asserted mid-stall clears everything; stallF/stallD drop as soon as validE=0.
//  - No internal state beyond the E register set (plus the optional counter).
// CONFIGURATION
//  ID_EX_STALL_CNT_EN defined:
//    - Adds output stallCnt [31:0], reset to 0.
//    - Increments on each edge where loadUse=1 and stallE=0 (i.e. a bubble is inserted).
//    - Saturates at 32'hFFFF_FFFF; flushE does not clear it.
//  Not defined: no stallCnt port and no counter logic; all other behaviour is identical.
// TESTING
//  T1 Reset: drive rst=0 mid-run with nonzero E state -> all E outputs and validE read 0 immediately, without a clock edge.
//  T2 Pass-through: D bundle with aluOpD=3, rsDataD=32'h1234_5678, rdD=5'd9, no hazard
//     -> one edge later aluOpE=3, rsDataE=32'h1234_5678, rdE=9, validE=1.
//  T3 Load-use: EX holds lw with rtE=8, memToRegE=1, Regfile_weE=1; ID has rsD=8
//     -> stallF=stallD=1 that cycle; next edge validE=0 with all controls 0.
//     The following edge loads the held instruction; stallCnt=1 when the counter is enabled.
//  T4 No false hazard: lw with rtE=0 and rsD=0 -> stallD=0, no bubble.
//     lw with rtE=8 but Regfile_weE=0 -> no stall.
//  T5 Priority: stallE=1 with loadUse=1 -> E unchanged and stallD=1.
//     flushE=1 with any D input -> bubble on that edge.
//  T6 Counter saturation (ID_EX_STALL_CNT_EN): force stallCnt to 32'hFFFF_FFFF, then one more hazard -> stallCnt stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use hazard detection and bubble injection.
// Optional feature: define ID_EX_STALL_CNT_EN to add the saturating stallCnt bubble counter.

`ifndef ALU_OP_LENGTH
`define ALU_OP_LENGTH 4
`endif
`ifndef REG_SRC_LENGTH
`define REG_SRC_LENGTH 3
`endif
`ifndef REG_DST_LENGTH
`define REG_DST_LENGTH 2
`endif

module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Regfile_weD,
  input  logic                       DataMem_weD,
  input  logic [`ALU_OP_LENGTH-1:0]  aluOpD,
  input  logic                       aluSrc2_muxD,
  input  logic [`REG_SRC_LENGTH-1:0] regSrc_muxD,
  input  logic [`REG_DST_LENGTH-1:0] regDst_muxD,
  input  logic                       memToRegD,
  input  logic [DATA_W-1:0]          pcD,
  input  logic [DATA_W-1:0]          rsDataD,
  input  logic [DATA_W-1:0]          rtDataD,
  input  logic [DATA_W-1:0]          immExtD,
  input  logic [REG_ADDR_W-1:0]      rsD,
  input  logic [REG_ADDR_W-1:0]      rtD,
  input  logic [REG_ADDR_W-1:0]      rdD,
  input  logic                       flushE,
  input  logic                       stallE,
  output logic                       stallF,
  output logic                       stallD,
  output logic                       validE,
  output logic                       Regfile_weE,
  output logic                       DataMem_weE,
  output logic [`ALU_OP_LENGTH-1:0]  aluOpE,
  output logic                       aluSrc2_muxE,
  output logic [`REG_SRC_LENGTH-1:0] regSrc_muxE,
  output logic [`REG_DST_LENGTH-1:0] regDst_muxE,
  output logic                       memToRegE,
  output logic [DATA_W-1:0]          pcE,
  output logic [DATA_W-1:0]          rsDataE,
  output logic [DATA_W-1:0]          rtDataE,
  output logic [DATA_W-1:0]          immExtE,
  output logic [REG_ADDR_W-1:0]      rsE,
  output logic [REG_ADDR_W-1:0]      rtE,
  output logic [REG_ADDR_W-1:0]      rdE
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]                stallCnt
`endif
);

  // Hold contract: while stallF/stallD are high the upstream stages must present the
  // same ID instruction again next cycle; stallE high freezes every E output as-is.

  typedef struct packed {
    logic                       regfile_we;
    logic                       datamem_we;
    logic [`ALU_OP_LENGTH-1:0]  alu_op;
    logic                       alu_src2;
    logic [`REG_SRC_LENGTH-1:0] reg_src;
    logic [`REG_DST_LENGTH-1:0] reg_dst;
    logic                       mem_to_reg;
    logic [DATA_W-1:0]          pc;
    logic [DATA_W-1:0]          rs_data;
    logic [DATA_W-1:0]          rt_data;
    logic [DATA_W-1:0]          imm_ext;
    logic [REG_ADDR_W-1:0]      rs;
    logic [REG_ADDR_W-1:0]      rt;
    logic [REG_ADDR_W-1:0]      rd;
  } ex_bundle_t;

  ex_bundle_t d_bundle;
  ex_bundle_t e_q;
  logic       valid_q;
  logic       load_use;
  logic       rt_match;
  logic       do_bubble;
  logic       do_load;

  assign d_bundle = '{
    regfile_we: Regfile_weD,
    datamem_we: DataMem_weD,
    alu_op:     aluOpD,
    alu_src2:   aluSrc2_muxD,
    reg_src:    regSrc_muxD,
    reg_dst:    regDst_muxD,
    mem_to_reg: memToRegD,
    pc:         pcD,
    rs_data:    rsDataD,
    rt_data:    rtDataD,
    imm_ext:    immExtD,
    rs:         rsD,
    rt:         rtD,
    rd:         rdD
  };

  // A load in EX whose destination ($zero excluded) is read by the ID instruction.
  assign rt_match = (e_q.rt == rsD) | (e_q.rt == rtD);
  assign load_use = valid_q & e_q.mem_to_reg & e_q.regfile_we & (e_q.rt != '0) & rt_match;

  assign stallF = load_use | stallE;
  assign stallD = load_use | stallE;

  // Flush beats hold, hold beats the load-use bubble; otherwise the D bundle advances.
  assign do_bubble = flushE | (~stallE & load_use);
  assign do_load   = ~flushE & ~stallE & ~load_use;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q     <= '0;
      valid_q <= 1'b0;
    end else if (do_bubble) begin
      e_q     <= '0;
      valid_q <= 1'b0;
    end else if (do_load) begin
      e_q     <= d_bundle;
      valid_q <= 1'b1;
    end
  end

  assign validE       = valid_q;
  assign Regfile_weE  = e_q.regfile_we;
  assign DataMem_weE  = e_q.datamem_we;
  assign aluOpE       = e_q.alu_op;
  assign aluSrc2_muxE = e_q.alu_src2;
  assign regSrc_muxE  = e_q.reg_src;
  assign regDst_muxE  = e_q.reg_dst;
  assign memToRegE    = e_q.mem_to_reg;
  assign pcE          = e_q.pc;
  assign rsDataE      = e_q.rs_data;
  assign rtDataE      = e_q.rt_data;
  assign immExtE      = e_q.imm_ext;
  assign rsE          = e_q.rs;
  assign rtE          = e_q.rt;
  assign rdE          = e_q.rd;

`ifdef ID_EX_STALL_CNT_EN
  // Counts inserted load-use bubbles; saturates and survives flushes.
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (load_use && !stallE && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stallCnt = stall_cnt_q;
`endif

endmodule
